// File: rtl/sattn_job_sched.sv
// sattn_job_sched: round-robin job scheduler in front of one sparse-attention
// accelerator. It grants one requester at a time, programs the accelerator's
// MMIO register file (8 operand writes, then CMD), waits for acc_done with a
// timeout, and returns a tagged completion.
// Optional feature macro: SATTN_JOB_SCHED_PERF_EN adds perf_jobs and
// perf_wait_cycles counters.
module sattn_job_sched #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 64,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int DESC_W     = 392
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DESC_W-1:0] req_desc,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      rsp_err,
    output logic                      mmio_wen,
    output logic                      mmio_ren,
    output logic [ADDR_WIDTH-1:0]     mmio_addr,
    output logic [DATA_WIDTH-1:0]     mmio_wdata,
    input  logic                      acc_done,
`ifdef SATTN_JOB_SCHED_PERF_EN
    output logic [31:0]               perf_jobs,
    output logic [31:0]               perf_wait_cycles,
`endif
    output logic                      sched_busy
);

    typedef enum logic [2:0] {S_IDLE, S_PROG, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                  state_q;
    logic [ID_W-1:0]         rr_ptr_q;
    logic [DESC_W-1:0]       desc_q;
    logic [2:0]              idx_q;
    logic [31:0]             wait_cnt_q;
    logic                    rsp_valid_q;
    logic [ID_W-1:0]         rsp_id_q;
    logic                    rsp_err_q;
    logic                    mmio_wen_q;
    logic [ADDR_WIDTH-1:0]   mmio_addr_q;
    logic [DATA_WIDTH-1:0]   mmio_wdata_q;

    logic                    win_found;
    logic [ID_W-1:0]         win_idx;
    logic [ID_W-1:0]         rr_ptr_d;
    logic [DESC_W-1:0]       win_desc;
    int                      scan_idx;

    // Register offset of operand write number i: four 64-bit bases, a gap,
    // then the four 32-bit shape fields.
    function automatic logic [ADDR_WIDTH-1:0] prog_addr(input logic [2:0] i);
        logic [7:0] a;
        if (i < 3'd4) a = {2'b00, i, 3'b000};
        else          a = 8'h30 + {2'b00, i - 3'd4, 3'b000};
        return ADDR_WIDTH'(a);
    endfunction

    // Data for operand write number i, shape fields zero-extended.
    function automatic logic [DATA_WIDTH-1:0] prog_data(input logic [DESC_W-1:0] d,
                                                        input logic [2:0] i);
        logic [63:0] v;
        case (i)
            3'd0:    v = d[63:0];
            3'd1:    v = d[127:64];
            3'd2:    v = d[191:128];
            3'd3:    v = d[255:192];
            3'd4:    v = {32'd0, d[287:256]};
            3'd5:    v = {32'd0, d[319:288]};
            3'd6:    v = {32'd0, d[351:320]};
            default: v = {32'd0, d[383:352]};
        endcase
        return DATA_WIDTH'(v);
    endfunction

    // Round-robin scan starting at rr_ptr; first valid requester wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!win_found && req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(scan_idx);
            end
        end
        win_desc = req_desc[int'(win_idx)*DESC_W +: DESC_W];
        rr_ptr_d = (int'(win_idx) == NUM_REQ-1) ? '0 : win_idx + 1'b1;
    end

    // The grant strobe must land in the same cycle the request is seen, so it
    // is decoded from the registered state rather than registered itself.
    assign req_ready  = (state_q == S_IDLE && win_found)
                        ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx) : '0;
    assign sched_busy = (state_q != S_IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_err    = rsp_err_q;
    assign mmio_wen   = mmio_wen_q;
    assign mmio_ren   = 1'b0;
    assign mmio_addr  = mmio_addr_q;
    assign mmio_wdata = mmio_wdata_q;

    // Job FSM; MMIO and response outputs are loaded together with the state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            desc_q       <= '0;
            idx_q        <= '0;
            wait_cnt_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_err_q    <= 1'b0;
            mmio_wen_q   <= 1'b0;
            mmio_addr_q  <= '0;
            mmio_wdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        desc_q   <= win_desc;
                        rsp_id_q <= win_idx;
                        rr_ptr_q <= rr_ptr_d;
                        if (win_desc[391:384] == 8'h00) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                        end else begin
                            state_q      <= S_PROG;
                            idx_q        <= 3'd0;
                            mmio_wen_q   <= 1'b1;
                            mmio_addr_q  <= prog_addr(3'd0);
                            mmio_wdata_q <= prog_data(win_desc, 3'd0);
                        end
                    end
                end
                S_PROG: begin
                    if (idx_q == 3'd7) begin
                        state_q      <= S_ISSUE;
                        mmio_addr_q  <= ADDR_WIDTH'(16'h0060);
                        mmio_wdata_q <= DATA_WIDTH'({56'd0, desc_q[391:384]});
                    end else begin
                        idx_q        <= idx_q + 3'd1;
                        mmio_addr_q  <= prog_addr(idx_q + 3'd1);
                        mmio_wdata_q <= prog_data(desc_q, idx_q + 3'd1);
                    end
                end
                S_ISSUE: begin
                    state_q      <= S_WAIT;
                    wait_cnt_q   <= '0;
                    mmio_wen_q   <= 1'b0;
                    mmio_addr_q  <= '0;
                    mmio_wdata_q <= '0;
                end
                S_WAIT: begin
                    // A done in the final timeout cycle still counts as success.
                    if (acc_done) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                    end else if (wait_cnt_q == 32'(TIMEOUT_CYC-1)) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                    end else begin
                        wait_cnt_q  <= wait_cnt_q + 32'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef SATTN_JOB_SCHED_PERF_EN
    logic [31:0] perf_jobs_q;
    logic [31:0] perf_wait_q;

    // Completed non-NOP jobs (wrapping) and WAIT-state cycles (saturating).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_jobs_q <= '0;
            perf_wait_q <= '0;
        end else begin
            if (state_q == S_RESP && rsp_ready && desc_q[391:384] != 8'h00)
                perf_jobs_q <= perf_jobs_q + 32'd1;
            if (state_q == S_WAIT && perf_wait_q != 32'hFFFF_FFFF)
                perf_wait_q <= perf_wait_q + 32'd1;
        end
    end

    assign perf_jobs        = perf_jobs_q;
    assign perf_wait_cycles = perf_wait_q;
`endif

endmodule

// File: tb/tb_sattn_job_sched.sv
// tb_sattn_job_sched: directed sequence with randomized descriptors for
// sattn_job_sched. A reference model derives the grant order from the
// round-robin rule and the expected MMIO write list from descriptor fields.
module tb_sattn_job_sched;

    localparam int NR = 4;
    localparam int DW = 392;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rstn;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*DW-1:0] req_desc;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic             rsp_err;
    logic             mmio_wen;
    logic             mmio_ren;
    logic [15:0]      mmio_addr;
    logic [63:0]      mmio_wdata;
    logic             acc_done;
    logic             sched_busy;

    always #5 clk = ~clk;

    sattn_job_sched #(
        .NUM_REQ(NR), .TIMEOUT_CYC(TO), .ADDR_WIDTH(16), .DATA_WIDTH(64)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_desc(req_desc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .mmio_wen(mmio_wen), .mmio_ren(mmio_ren), .mmio_addr(mmio_addr),
        .mmio_wdata(mmio_wdata), .acc_done(acc_done), .sched_busy(sched_busy)
    );

    int          checks = 0;
    int          errors = 0;
    int          rr_m   = 0;
    logic [DW-1:0] desc_m [NR];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] make_desc(input logic [7:0] cmd);
        return {cmd, $urandom, $urandom, $urandom, $urandom,
                {$urandom, $urandom}, {$urandom, $urandom},
                {$urandom, $urandom}, {$urandom, $urandom}};
    endfunction

    task automatic set_desc(input int i, input logic [DW-1:0] d);
        desc_m[i] = d;
        req_desc[DW*i +: DW] = d;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // One full job starting in the current IDLE cycle. wait_d = WAIT cycle in
    // which done is pulsed (0 = never); hold = cycles rsp_ready stays low;
    // abort_w = WAIT cycle in which rstn is pulsed (-1 = none).
    task automatic run_job(input int wait_d, input int hold, input bit drop,
                           input bit prog_done, input int abort_w);
        int          win;
        int          nw;
        bit          eerr;
        logic [DW-1:0] d;
        logic [7:0]  cmd;
        logic [15:0] ea [9];
        logic [63:0] ed [9];
        #1;
        win = -1;
        for (int k = 0; k < NR; k++)
            if (win < 0 && req_valid[(rr_m + k) % NR]) win = (rr_m + k) % NR;
        if (win < 0) begin
            checks++;
            errors++;
            $error("FAIL grant_none got=none exp=some");
            return;
        end
        chk("grant", req_ready, 64'(1 << win));
        chk("grant_wen", mmio_wen, 0);
        d    = desc_m[win];
        cmd  = d[391:384];
        rr_m = (win + 1) % NR;
        ea = '{16'h0000, 16'h0008, 16'h0010, 16'h0018,
               16'h0030, 16'h0038, 16'h0040, 16'h0048, 16'h0060};
        ed[0] = d[63:0];    ed[1] = d[127:64];
        ed[2] = d[191:128]; ed[3] = d[255:192];
        ed[4] = {32'd0, d[287:256]}; ed[5] = {32'd0, d[319:288]};
        ed[6] = {32'd0, d[351:320]}; ed[7] = {32'd0, d[383:352]};
        ed[8] = {56'd0, cmd};
        eerr = 1'b0;
        nxt();
        if (drop) req_valid[win] = 1'b0;
        else      set_desc(win, make_desc(8'($urandom_range(1, 255))));
        if (cmd != 8'h00) begin
            for (int i = 0; i < 9; i++) begin
                acc_done = prog_done && (i == 3);
                #1;
                chk("prog_wen", mmio_wen, 1);
                chk("prog_addr", mmio_addr, ea[i]);
                chk("prog_data", mmio_wdata, ed[i]);
                chk("prog_nogrant", req_ready, 0);
                chk("prog_rsp", rsp_valid, 0);
                nxt();
                acc_done = 1'b0;
            end
            nw   = (wait_d >= 1 && wait_d <= TO) ? wait_d : TO;
            eerr = !(wait_d >= 1 && wait_d <= TO);
            for (int w = 0; w < nw; w++) begin
                if (w == abort_w) begin
                    rstn = 1'b0;
                    #1;
                    chk("rst_rsp_valid", rsp_valid, 0);
                    chk("rst_rsp_id", rsp_id, 0);
                    chk("rst_rsp_err", rsp_err, 0);
                    chk("rst_wen", mmio_wen, 0);
                    chk("rst_addr", mmio_addr, 0);
                    chk("rst_wdata", mmio_wdata, 0);
                    chk("rst_busy", sched_busy, 0);
                    rr_m = 0;
                    nxt();
                    rstn = 1'b1;
                    #1;
                    chk("rst_rsp_after", rsp_valid, 0);
                    return;
                end
                acc_done = (w == wait_d - 1);
                #1;
                chk("wait_wen", mmio_wen, 0);
                chk("wait_addr", mmio_addr, 0);
                chk("wait_data", mmio_wdata, 0);
                chk("wait_rsp", rsp_valid, 0);
                chk("wait_busy", sched_busy, 1);
                nxt();
                acc_done = 1'b0;
            end
        end
        for (int h = 0; h <= hold; h++) begin
            rsp_ready = (h == hold);
            #1;
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_id", rsp_id, 64'(win));
            chk("rsp_err", rsp_err, 64'(eerr));
            chk("rsp_wen", mmio_wen, 0);
            chk("rsp_nogrant", req_ready, 0);
            nxt();
        end
        rsp_ready = 1'b0;
        #1;
        chk("rsp_drop", rsp_valid, 0);
        chk("idle_busy", sched_busy, 0);
    endtask

    initial begin
        logic [DW-1:0] d;
        req_valid = '0;
        req_desc  = '0;
        rsp_ready = 1'b0;
        acc_done  = 1'b0;
        for (int i = 0; i < NR; i++) desc_m[i] = '0;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_wen", mmio_wen, 0);
        chk("reset_ren", mmio_ren, 0);
        chk("reset_addr", mmio_addr, 0);
        chk("reset_wdata", mmio_wdata, 0);
        chk("reset_busy", sched_busy, 0);
        rstn = 1'b1;
        nxt();

        // single job from requester 0, done in the 9th WAIT cycle
        d = make_desc(8'h14);
        d[63:0] = 64'h1000;
        set_desc(0, d);
        req_valid = 4'b0001;
        run_job(9, 0, 1'b1, 1'b0, -1);

        // NOP from requester 2
        set_desc(2, make_desc(8'h00));
        req_valid[2] = 1'b1;
        run_job(1, 0, 1'b1, 1'b0, -1);

        // timeout from requester 1
        set_desc(1, make_desc(8'($urandom_range(1, 255))));
        req_valid[1] = 1'b1;
        run_job(0, 0, 1'b1, 1'b0, -1);

        // done in the final timeout cycle; stray done during PROG
        set_desc(3, make_desc(8'($urandom_range(1, 255))));
        req_valid[3] = 1'b1;
        run_job(TO, 0, 1'b1, 1'b1, -1);

        // rsp_ready held low 5 cycles while another requester waits
        set_desc(0, make_desc(8'($urandom_range(1, 255))));
        set_desc(1, make_desc(8'($urandom_range(1, 255))));
        req_valid = 4'b0011;
        run_job(2, 5, 1'b1, 1'b0, -1);
        run_job(1, 0, 1'b1, 1'b0, -1);

        // reset mid-WAIT aborts silently and rewinds the pointer
        set_desc(2, make_desc(8'($urandom_range(1, 255))));
        req_valid[2] = 1'b1;
        run_job(5, 0, 1'b1, 1'b0, 2);
        req_valid = '0;

        // all four requesters continuously valid
        for (int i = 0; i < NR; i++) set_desc(i, make_desc(8'($urandom_range(1, 255))));
        req_valid = 4'b1111;
        for (int j = 0; j < 5; j++) run_job(int'($urandom_range(1, 3)), 0, 1'b0, 1'b0, -1);
        req_valid = '0;
        nxt();
        #1;
        chk("end_ready", req_ready, 0);
        chk("end_busy", sched_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
